// File: rtl/prog_run_ctrl.sv
// Top-level load/run/dump sequencer for the 16-bit core: streams a program into
// instruction memory, runs the core under a watchdog, then scans out registers.
module prog_run_ctrl #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned INSTR_W    = 16,
    parameter int unsigned REG_W      = 8,
    parameter int unsigned NUM_REGS   = 4,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned MAX_CYCLES = 1000,
    localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_data,
    output logic               cpu_reset,
    output logic               cpu_run,
    input  logic               cpu_halt,
    output logic               read_enable,
    output logic [IDX_W-1:0]   read_address,
    input  logic [REG_W-1:0]   reg_value,
    output logic               dump_valid,
    output logic [IDX_W-1:0]   dump_index,
    output logic [REG_W-1:0]   dump_data,
    output logic [ADDR_W:0]    prog_len,
    output logic               done,
    output logic               timeout,
    output logic               load_ovf
);

    // One shared phase counter covers the CPURST hold, the RUN watchdog and the DUMP scan.
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + RST_CYCLES + NUM_REGS + 1);
    localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DUMP_LAST = CNT_W'(NUM_REGS);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {StIdle, StLoad, StCpuRst, StRun, StDump, StDone} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic               timeout_q, timeout_d;
    logic               ovf_q, ovf_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]   dump_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            len_q     <= '0;
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            timeout_q <= timeout_d;
            ovf_q     <= ovf_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        len_d     = len_q;
        timeout_d = timeout_q;
        ovf_d     = ovf_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        unique case (state_q)
            StIdle, StDone: begin
                cnt_d = '0;
                if (start) begin
                    state_d   = StLoad;
                    len_d     = '0;
                    timeout_d = 1'b0;
                    ovf_d     = 1'b0;
                end
            end
            StLoad: begin
                cnt_d = '0;
                if (load_valid) begin
                    we_d   = 1'b1;
                    addr_d = len_q[ADDR_W-1:0];
                    data_d = load_data;
                    len_d  = len_q + 1'b1;
                    if (load_last) begin
                        state_d = StCpuRst;
                    end else if (len_q[ADDR_W-1:0] == ADDR_LAST) begin
                        // Memory full: stop rather than wrap over word 0.
                        ovf_d   = 1'b1;
                        state_d = StCpuRst;
                    end
                end
            end
            StCpuRst: begin
                if (cnt_q == RST_LAST) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (cpu_halt) begin
                    state_d = StDump;
                    cnt_d   = '0;
                end else if (cnt_q == RUN_LAST) begin
                    state_d   = StDump;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            StDump: begin
                if (cnt_q == DUMP_LAST) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dump_cnt = cnt_q - 1'b1;

    assign load_ready   = (state_q == StLoad);
    assign cpu_reset    = state_q inside {StIdle, StLoad, StCpuRst};
    assign cpu_run      = (state_q == StRun);
    assign read_enable  = (state_q == StDump) && (cnt_q < DUMP_LAST);
    assign read_address = read_enable ? cnt_q[IDX_W-1:0] : '0;
    // reg_value already trails read_address by one cycle, so it is forwarded as-is.
    assign dump_valid   = (state_q == StDump) && (cnt_q != '0);
    assign dump_index   = dump_valid ? dump_cnt[IDX_W-1:0] : '0;
    assign dump_data    = dump_valid ? reg_value : '0;
    assign done         = (state_q == StDone);
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_data    = data_q;
    assign prog_len     = len_q;
    assign timeout      = timeout_q;
    assign load_ovf     = ovf_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Randomized bench for prog_run_ctrl: a phase/elapsed-cycle reference model is
// compared against the DUT every cycle, plus hand-computed scenario checks.
module tb_prog_run_ctrl;
    localparam int ADDR_W = 8, INSTR_W = 16, REG_W = 8, NUM_REGS = 4;
    localparam int RST_CYCLES = 2, MAX_CYCLES = 1000;
    localparam int IDLE = 0, LOAD = 1, RST = 2, RUN = 3, DUMP = 4, DONE = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, start, load_valid, load_last, load_ready;
    logic [INSTR_W-1:0] load_data;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               cpu_reset, cpu_run, cpu_halt, read_enable;
    logic [1:0]         read_address, dump_index;
    logic [REG_W-1:0]   reg_value = '0;
    logic               dump_valid;
    logic [REG_W-1:0]   dump_data;
    logic [ADDR_W:0]    prog_len;
    logic               done, timeout, load_ovf;

    prog_run_ctrl #(
        .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .REG_W(REG_W), .NUM_REGS(NUM_REGS),
        .RST_CYCLES(RST_CYCLES), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
        .cpu_reset(cpu_reset), .cpu_run(cpu_run), .cpu_halt(cpu_halt),
        .read_enable(read_enable), .read_address(read_address), .reg_value(reg_value),
        .dump_valid(dump_valid), .dump_index(dump_index), .dump_data(dump_data),
        .prog_len(prog_len), .done(done), .timeout(timeout), .load_ovf(load_ovf)
    );

    // Register file stand-in: one cycle read latency.
    logic [REG_W-1:0] regs [NUM_REGS];
    always @(posedge clk) reg_value <= regs[read_address];

    // Reference model: current phase and cycles elapsed in it.
    int         m_phase = IDLE, m_cnt = 0, m_len = 0, m_addr = 0;
    bit         m_to = 0, m_ovf = 0, m_we = 0;
    logic [15:0] m_data = '0;

    always @(posedge clk) begin
        m_we <= 1'b0;
        if (reset) begin
            m_phase <= IDLE; m_cnt <= 0; m_len <= 0; m_to <= 0; m_ovf <= 0;
        end else begin
            m_cnt <= m_cnt + 1;
            case (m_phase)
                IDLE, DONE: if (start) begin
                    m_phase <= LOAD; m_cnt <= 0; m_len <= 0; m_to <= 0; m_ovf <= 0;
                end
                LOAD: if (load_valid) begin
                    m_we <= 1'b1; m_addr <= m_len; m_data <= load_data; m_len <= m_len + 1;
                    if (load_last) begin
                        m_phase <= RST; m_cnt <= 0;
                    end else if (m_len == (1 << ADDR_W) - 1) begin
                        m_phase <= RST; m_cnt <= 0; m_ovf <= 1;
                    end
                end
                RST: if (m_cnt == RST_CYCLES - 1) begin m_phase <= RUN; m_cnt <= 0; end
                RUN: if (cpu_halt) begin
                    m_phase <= DUMP; m_cnt <= 0;
                end else if (m_cnt == MAX_CYCLES - 1) begin
                    m_phase <= DUMP; m_cnt <= 0; m_to <= 1;
                end
                DUMP: if (m_cnt == NUM_REGS) begin m_phase <= DONE; m_cnt <= 0; end
                default: m_phase <= IDLE;
            endcase
        end
    end

    int checks = 0, passes = 0, cyc = 0;
    int run_total = 0, run_start = 0, last_we = 0;
    bit prev_run = 0;
    logic [23:0] wq[$];
    logic [9:0]  dq[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic sample();
        bit ren, dv;
        @(negedge clk);
        cyc++;
        chk("cpu_reset", cpu_reset, m_phase <= RST);
        chk("cpu_run", cpu_run, m_phase == RUN);
        chk("load_ready", load_ready, m_phase == LOAD);
        chk("done", done, m_phase == DONE);
        chk("prog_len", prog_len, m_len);
        chk("timeout", timeout, m_to);
        chk("load_ovf", load_ovf, m_ovf);
        chk("imem_we", imem_we, m_we);
        if (m_we) begin
            chk("imem_addr", imem_addr, m_addr);
            chk("imem_data", imem_data, m_data);
        end
        ren = (m_phase == DUMP) && (m_cnt < NUM_REGS);
        chk("read_enable", read_enable, ren);
        if (ren) chk("read_address", read_address, m_cnt);
        dv = (m_phase == DUMP) && (m_cnt >= 1);
        chk("dump_valid", dump_valid, dv);
        if (dv) begin
            chk("dump_index", dump_index, m_cnt - 1);
            chk("dump_data", dump_data, regs[m_cnt-1]);
        end
        if (imem_we) begin wq.push_back({imem_addr, imem_data}); last_we = cyc; end
        if (cpu_run) begin run_total++; if (!prev_run) run_start = cyc; end
        prev_run = cpu_run;
        if (dump_valid) dq.push_back({dump_index, dump_data});
    endtask

    task automatic step();
        sample();
        @(posedge clk);
        #1;
    endtask

    int wq_base, dq_base, run_base;

    task automatic run_seq(input int nwords, input bit last, input bit gapped,
                           input bit mid_start, input int halt_at, input bit use_tbl);
        logic [15:0] tbl [3] = '{16'h1234, 16'h5678, 16'h9ABC};
        logic [23:0] ew[$];
        int w = 0, tries = 0;
        bit v;
        wq_base = wq.size(); dq_base = dq.size(); run_base = run_total;
        start = 1'b1; step(); start = 1'b0;
        while (w < nwords && tries < 4 * nwords + 8) begin
            v = !gapped || (tries % 2 == 0);
            load_valid = v;
            load_data  = use_tbl ? tbl[w % 3] : 16'($urandom);
            load_last  = last && (w == nwords - 1);
            start      = mid_start && (tries == 1);
            if (v) ew.push_back({8'(w), load_data});
            step();
            if (v) w++;
            tries++;
        end
        // Words offered after the final handshake must be ignored.
        start = 1'b0; load_last = 1'b0; load_valid = 1'b1;
        repeat (2) step();
        load_valid = 1'b0;
        tries = 0;
        while (!cpu_run && tries < 20) begin step(); tries++; end
        chk("run_entered", cpu_run, 1);
        if (halt_at >= 0) begin
            repeat (halt_at) step();
            cpu_halt = 1'b1; step(); cpu_halt = 1'b0;
        end
        tries = 0;
        while (!done && tries < MAX_CYCLES + 20) begin step(); tries++; end
        chk("done_reached", done, 1);
        step();
        chk("n_writes", wq.size() - wq_base, nwords);
        for (int i = 0; i < nwords && wq_base + i < wq.size(); i++)
            chk("write", wq[wq_base+i], ew[i]);
        chk("n_dumps", dq.size() - dq_base, NUM_REGS);
    endtask

    initial begin
        int zeros;
        reset = 1'b1; start = 0; load_valid = 0; load_data = '0; load_last = 0; cpu_halt = 0;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'(8'h10 + i);
        step(); step();
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_cpu_run", cpu_run, 0);
        chk("rst_done", done, 0);
        chk("rst_prog_len", prog_len, 0);
        chk("rst_imem_we", imem_we, 0);
        reset = 1'b0;
        step();

        // Three table words, halt on RUN cycle 5.
        run_seq(3, 1, 0, 0, 5, 1);
        chk("s1_prog_len", prog_len, 3);
        chk("s1_rst_hold", run_start - last_we, RST_CYCLES);
        chk("s1_run_len", run_total - run_base, 6);
        chk("s1_timeout", timeout, 0);
        chk("s1_done", done, 1);
        for (int i = 0; i < NUM_REGS && dq_base + i < dq.size(); i++)
            chk("s1_dump", dq[dq_base+i], (i << 8) | (16 + i));

        // Core never halts: watchdog.
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'($urandom);
        run_seq(5, 1, 0, 0, -1, 0);
        chk("to_run_len", run_total - run_base, 1000);
        chk("to_timeout", timeout, 1);
        chk("to_done", done, 1);

        // Halt on the very cycle the watchdog would expire.
        run_seq(2, 1, 0, 0, MAX_CYCLES - 1, 0);
        chk("tie_run_len", run_total - run_base, 1000);
        chk("tie_timeout", timeout, 0);

        // Fill the whole memory without load_last.
        run_seq(256, 0, 0, 0, 3, 0);
        chk("ovf_flag", load_ovf, 1);
        chk("ovf_prog_len", prog_len, 256);
        chk("ovf_last_addr", wq[wq.size()-1][23:16], 8'hFF);
        zeros = 0;
        for (int i = wq_base; i < wq.size(); i++) if (wq[i][23:16] == 8'h00) zeros++;
        chk("ovf_addr0_once", zeros, 1);

        // Gapped load with a stray start mid-LOAD.
        run_seq(4, 1, 1, 1, 2, 0);
        chk("gap_prog_len", prog_len, 4);
        chk("gap_ovf", load_ovf, 0);

        repeat (6) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'($urandom);
            run_seq($urandom_range(1, 10), 1, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 30), 0);
            chk("rnd_timeout", timeout, 0);
        end

        // Reset in the middle of RUN, then reload from address 0.
        start = 1'b1; step(); start = 1'b0;
        load_valid = 1'b1; load_data = 16'hAAAA; step();
        load_last = 1'b1; load_data = 16'h5555; step();
        load_valid = 1'b0; load_last = 1'b0;
        for (int i = 0; i < 10 && !cpu_run; i++) step();
        repeat (3) step();
        chk("mr_in_run", cpu_run, 1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("mr_cpu_reset", cpu_reset, 1);
        chk("mr_cpu_run", cpu_run, 0);
        chk("mr_done", done, 0);
        chk("mr_load_ready", load_ready, 0);
        step();
        run_seq(3, 1, 0, 0, 4, 0);
        chk("mr_first_addr", wq[wq_base][23:16], 8'h00);
        chk("mr_prog_len", prog_len, 3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
